// File: rtl/seg_display_mmio.sv
// Memory-mapped multiplexed 7-segment display controller (DATA at word 0, CTRL at word 1).
// Optional per-digit blink mask in CTRL[31:24] when SEG_DISPLAY_BLINK_EN is defined.
module seg_display_mmio #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024,
  parameter int BLINK_DIV   = 2**22
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           writeData,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic [29:0]           memAddress,
  output logic [31:0]           readData,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]  DIG_MASK  = 8'((16'd1 << NUM_DIGITS) - 16'd1);
  localparam logic [31:0] DATA_MASK = 32'((64'd1 << (4*NUM_DIGITS)) - 64'd1);
`ifdef SEG_DISPLAY_BLINK_EN
  localparam logic [7:0]  BLINK_MASK = DIG_MASK;
`else
  localparam logic [7:0]  BLINK_MASK = 8'h00;
`endif
  // Write mask doubles as the "unimplemented bits read 0" rule.
  localparam logic [31:0] CTRL_MASK = {BLINK_MASK, DIG_MASK, DIG_MASK, 8'h01};

  logic [31:0]           data_q, data_d, ctrl_q, ctrl_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  in_range, cnt_last;
  logic [3:0]            nib;
  logic                  blank_b, dp_b, hidden;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'b1000000;  4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;  4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;  4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;  4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;  4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;  4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;  4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;  default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign in_range = (memAddress[29:1] == 29'd0);

  // Read value comes from pre-write registers, so a same-cycle write is not visible.
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (readEnable)
      rd_d = !in_range ? 32'h0 : (memAddress[0] ? ctrl_q : data_q);
    if (writeEnable && in_range) begin
      if (memAddress[0]) ctrl_d = writeData & CTRL_MASK;
      else               data_d = writeData & DATA_MASK;
    end
  end

  assign cnt_last = (cnt_q == CW'(REFRESH_DIV - 1));
  assign cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
  assign idx_d    = !cnt_last ? idx_q :
                    (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

`ifdef SEG_DISPLAY_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt_q;
  logic          phase_q, blink_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q  <= '0;
      phase_q <= 1'b1;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + 1'b1;
    end
  end
`endif

  always_comb begin
    nib     = '0;
    blank_b = 1'b0;
    dp_b    = 1'b0;
`ifdef SEG_DISPLAY_BLINK_EN
    blink_b = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib     = data_q[4*i +: 4];
        blank_b = ctrl_q[8+i];
        dp_b    = ctrl_q[16+i];
`ifdef SEG_DISPLAY_BLINK_EN
        blink_b = ctrl_q[24+i];
`endif
      end
    end
  end

`ifdef SEG_DISPLAY_BLINK_EN
  assign hidden = blank_b | (blink_b & ~phase_q);
`else
  assign hidden = blank_b;
`endif

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (ctrl_q[0]) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!hidden) begin
        seg_d = hex_glyph(nib);
        dp_d  = ~dp_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      ctrl_q <= 32'h0000_0001;
      rd_q   <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= '1;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign readData = rd_q;
  assign an       = an_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule

// File: tb/tb_seg_display_mmio.sv
// Self-checking bench for seg_display_mmio: directed scenarios plus randomized bus traffic
// checked against a time-based behavioural model of the display.
module tb_seg_display_mmio;
  localparam int ND = 4, RD = 4, BD = 8;
  localparam logic [31:0] DMASK = 32'h0000_FFFF;
`ifdef SEG_DISPLAY_BLINK_EN
  localparam logic [31:0] CMASK = 32'h0F0F_0F01;
`else
  localparam logic [31:0] CMASK = 32'h000F_0F01;
`endif

  logic          clk = 1'b0, rst = 1'b1;
  logic [31:0]   writeData = '0;
  logic          writeEnable = 1'b0, readEnable = 1'b0;
  logic [29:0]   memAddress = '0;
  logic [31:0]   readData;
  logic [6:0]    seg;
  logic          dp;
  logic [ND-1:0] an;

  int checks = 0, errors = 0;

  seg_display_mmio #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .writeData(writeData), .writeEnable(writeEnable),
    .readEnable(readEnable), .memAddress(memAddress), .readData(readData),
    .seg(seg), .dp(dp), .an(an));

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  // Model: t = clk edges since reset release; digit on show = (t/RD)%ND, blink on while (t/BD) even.
  int            t = 0, m_idx = 0;
  logic [31:0]   m_data = '0, m_ctrl = 32'h1, exp_rd = '0;
  logic [ND-1:0] exp_an = '1;
  logic [6:0]    exp_seg = 7'h7F;
  logic          exp_dp = 1'b1;

  always @(posedge clk) begin
    int   i;
    logic hide;
    if (rst) begin
      t = 0; m_idx = 0; m_data = '0; m_ctrl = 32'h1; exp_rd = '0;
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      i = (t / RD) % ND;
      m_idx = i;
      hide = m_ctrl[8+i];
`ifdef SEG_DISPLAY_BLINK_EN
      if (m_ctrl[24+i] && ((t / BD) % 2 == 1)) hide = 1'b1;
`endif
      exp_an = '1; exp_seg = 7'h7F; exp_dp = 1'b1;
      if (m_ctrl[0]) begin
        exp_an[i] = 1'b0;
        if (!hide) begin
          exp_seg = glyph(m_data[4*i +: 4]);
          exp_dp  = ~m_ctrl[16+i];
        end
      end
      if (readEnable)
        exp_rd = (memAddress[29:1] != 0) ? 32'h0 : (memAddress[0] ? m_ctrl : m_data);
      if (writeEnable && memAddress[29:1] == 0) begin
        if (memAddress[0]) m_ctrl = writeData & CMASK;
        else               m_data = writeData & DMASK;
      end
      t++;
    end
  end

  task automatic bus_write(input logic [29:0] a, input logic [31:0] d);
    memAddress = a; writeData = d; writeEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0;
  endtask

  task automatic bus_read(input logic [29:0] a);
    memAddress = a; readEnable = 1'b1;
    @(negedge clk);
    readEnable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; writeEnable = 1'b1; readEnable = 1'b1;
    memAddress = 30'd0; writeData = $urandom;
    @(negedge clk); @(negedge clk);
    checks += 4;
    if (an !== 4'hF)     begin errors++; $display("FAIL reset_an: got %b expected 1111", an); end
    if (seg !== 7'h7F)   begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    if (dp !== 1'b1)     begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
    if (readData !== 0)  begin errors++; $display("FAIL reset_rd: got %h expected 0", readData); end
    rst = 1'b0; writeEnable = 1'b0; readEnable = 1'b0;
    @(negedge clk);
    checks += 3;
    if (an !== 4'b1110)      begin errors++; $display("FAIL first_an: got %b expected 1110", an); end
    if (seg !== 7'b1000000)  begin errors++; $display("FAIL first_seg: got %b expected 1000000", seg); end
    if (dp !== 1'b1)         begin errors++; $display("FAIL first_dp: got %b expected 1", dp); end
  endtask

  // Must run straight after test_reset: edge k after release shows digit ((k-1)/4)%4.
  task automatic test_scan();
    logic [ND-1:0] e;
    for (int k = 2; k <= 20; k++) begin
      @(negedge clk);
      e = ~(4'b0001 << (((k - 1) / RD) % ND));
      checks++;
      if (an !== e) begin errors++; $display("FAIL scan_an[%0d]: got %b expected %b", k, an, e); end
    end
  endtask

  task automatic test_data();
    logic [6:0] tbl [4];
    tbl[0] = 7'b0110000; tbl[1] = 7'b0001110; tbl[2] = 7'b0010010; tbl[3] = 7'b0001000;
    bus_write(30'd0, 32'h0000_A5F3);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      checks += 2;
      if (seg !== tbl[m_idx]) begin errors++; $display("FAIL data_seg[%0d]: got %b expected %b", m_idx, seg, tbl[m_idx]); end
      if (an !== exp_an)      begin errors++; $display("FAIL data_an: got %b expected %b", an, exp_an); end
      @(negedge clk);
    end
  endtask

  task automatic test_ctrl_blank();
    bus_write(30'd1, 32'h0002_0201);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      checks += 3;
      if (dp !== 1'b1)     begin errors++; $display("FAIL blank_dp[%0d]: got %b expected 1", m_idx, dp); end
      if (seg !== exp_seg) begin errors++; $display("FAIL blank_seg_model: got %b expected %b", seg, exp_seg); end
      if (an !== exp_an)   begin errors++; $display("FAIL blank_an: got %b expected %b", an, exp_an); end
      if (m_idx == 1) begin
        checks++;
        if (seg !== 7'h7F) begin errors++; $display("FAIL blank_seg1: got %h expected 7f", seg); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_disable();
    bit seen = 1'b0;
    bus_write(30'd1, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (an === 4'hF && seg === 7'h7F && dp === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL disable_within2: got an=%b seg=%h expected 1111/7f", an, seg); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF) begin errors++; $display("FAIL disable_hold: got %b expected 1111", an); end
    end
    bus_write(30'd1, 32'h1);
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      checks += 2;
      if (an !== exp_an)   begin errors++; $display("FAIL resume_an: got %b expected %b", an, exp_an); end
      if (seg !== exp_seg) begin errors++; $display("FAIL resume_seg: got %b expected %b", seg, exp_seg); end
      @(negedge clk);
    end
  endtask

  task automatic test_reads();
    bus_read(30'd1);
    checks++;
    if (readData !== 32'h1) begin errors++; $display("FAIL read_ctrl: got %h expected 00000001", readData); end
    bus_read(30'd2);
    checks++;
    if (readData !== 32'h0) begin errors++; $display("FAIL read_oob: got %h expected 0", readData); end
    bus_write(30'd3, 32'hFFFF_FFFF);
    bus_read(30'd1);
    checks++;
    if (readData !== 32'h1) begin errors++; $display("FAIL oob_write_ignored: got %h expected 00000001", readData); end
    memAddress = 30'd0; writeData = 32'h0000_1234; writeEnable = 1'b1; readEnable = 1'b1;
    @(negedge clk);
    writeEnable = 1'b0; readEnable = 1'b0;
    checks++;
    if (readData !== 32'h0000_A5F3) begin errors++; $display("FAIL rw_same: got %h expected 0000a5f3", readData); end
    bus_write(30'd0, 32'h0000_9999);
    repeat (3) @(negedge clk);
    checks++;
    if (readData !== 32'h0000_A5F3) begin errors++; $display("FAIL rd_hold: got %h expected 0000a5f3", readData); end
    bus_write(30'd0, 32'hFFFF_FFFF);
    bus_read(30'd0);
    checks++;
    if (readData !== 32'h0000_FFFF) begin errors++; $display("FAIL data_mask: got %h expected 0000ffff", readData); end
    bus_write(30'd1, 32'hFFFF_FFFF);
    bus_read(30'd1);
    checks++;
    if (readData !== CMASK) begin errors++; $display("FAIL ctrl_mask: got %h expected %h", readData, CMASK); end
    bus_write(30'd1, 32'h1);
  endtask

  task automatic test_random();
    int r;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      checks += 4;
      if (an !== exp_an)         begin errors++; $display("FAIL rand_an[%0d]: got %b expected %b", k, an, exp_an); end
      if (seg !== exp_seg)       begin errors++; $display("FAIL rand_seg[%0d]: got %b expected %b", k, seg, exp_seg); end
      if (dp !== exp_dp)         begin errors++; $display("FAIL rand_dp[%0d]: got %b expected %b", k, dp, exp_dp); end
      if (readData !== exp_rd)   begin errors++; $display("FAIL rand_rd[%0d]: got %h expected %h", k, readData, exp_rd); end
      r = $urandom_range(0, 9);
      memAddress  = (r < 4) ? 30'd0 : (r < 8) ? 30'd1 : 30'($urandom);
      writeData   = $urandom;
      if (memAddress == 30'd1 && $urandom_range(0, 3) != 0) writeData[0] = 1'b1;
      writeEnable = ($urandom_range(0, 5) == 0);
      readEnable  = ($urandom_range(0, 1) == 0);
    end
    writeEnable = 1'b0; readEnable = 1'b0;
  endtask

  task automatic test_mid_reset();
    repeat (5) @(negedge clk);
    rst = 1'b1; writeEnable = 1'b1; readEnable = 1'b1;
    memAddress = 30'd1; writeData = 32'h0000_0F00;
    @(negedge clk);
    checks += 4;
    if (an !== 4'hF)      begin errors++; $display("FAIL midrst_an: got %b expected 1111", an); end
    if (seg !== 7'h7F)    begin errors++; $display("FAIL midrst_seg: got %h expected 7f", seg); end
    if (dp !== 1'b1)      begin errors++; $display("FAIL midrst_dp: got %b expected 1", dp); end
    if (readData !== 0)   begin errors++; $display("FAIL midrst_rd: got %h expected 0", readData); end
    rst = 1'b0; writeEnable = 1'b0; readEnable = 1'b0;
    @(negedge clk);
    checks += 2;
    if (an !== 4'b1110)     begin errors++; $display("FAIL midrst_first_an: got %b expected 1110", an); end
    if (seg !== 7'b1000000) begin errors++; $display("FAIL midrst_first_seg: got %b expected 1000000", seg); end
    bus_read(30'd0);
    checks++;
    if (readData !== 0) begin errors++; $display("FAIL midrst_data: got %h expected 0", readData); end
    bus_read(30'd1);
    checks++;
    if (readData !== 32'h1) begin errors++; $display("FAIL midrst_ctrl: got %h expected 00000001", readData); end
  endtask

`ifdef SEG_DISPLAY_BLINK_EN
  task automatic test_blink();
    bus_write(30'd0, 32'h0000_0008);
    bus_write(30'd1, 32'h0100_0001);
    @(negedge clk);
    for (int k = 0; k < 64; k++) begin
      checks += 3;
      if (an !== exp_an)   begin errors++; $display("FAIL blink_an: got %b expected %b", an, exp_an); end
      if (seg !== exp_seg) begin errors++; $display("FAIL blink_seg: got %b expected %b", seg, exp_seg); end
      if (dp !== exp_dp)   begin errors++; $display("FAIL blink_dp: got %b expected %b", dp, exp_dp); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_data();
    test_ctrl_blank();
    test_disable();
    test_reads();
    test_random();
    test_mid_reset();
`ifdef SEG_DISPLAY_BLINK_EN
    test_blink();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
